// File: rtl/meter_core.sv
// meter_core: parking-meter timekeeper. Debounces coin buttons, adds saturating increments, counts down once per tick.
// Optional macro METER_BCD_OUT_EN adds a registered four-digit BCD copy of count on port bcd.
module meter_core #(
   parameter int unsigned TICK_CYCLES  = 100000000,
   parameter int unsigned DEB_CYCLES   = 250000,
   parameter int unsigned NUM_BTN      = 4,
   parameter int unsigned COUNT_W      = 16,
   parameter int unsigned MAX_COUNT    = 9999,
   parameter logic [NUM_BTN*COUNT_W-1:0] INC_LIST = {16'd550, 16'd200, 16'd180, 16'd10},
   parameter int unsigned PRESET_A     = 10,
   parameter int unsigned PRESET_B     = 205,
   parameter int unsigned LOW_THRESH   = 200,
   parameter int unsigned FLASH_CYCLES = 50000000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_BTN-1:0] btn,
   input  logic [1:0]         preset,
   output logic [COUNT_W-1:0] count,
   output logic [1:0]         state,
   output logic               display_en,
   output logic               expired_pulse
`ifdef METER_BCD_OUT_EN
   ,
   output logic [15:0]        bcd
`endif
);
   // state      | meaning
   // ST_EXPIRED | count is zero
   // ST_LOW     | 0 < count < LOW_THRESH, display flashes
   // ST_OK      | count >= LOW_THRESH, display steady
   typedef enum logic [1:0] {ST_EXPIRED = 2'b00, ST_LOW = 2'b01, ST_OK = 2'b10} state_e;

   localparam int unsigned TICK_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int unsigned DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int unsigned FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
   localparam int unsigned EXT_W   = COUNT_W + $clog2(NUM_BTN) + 1;

   logic               rst_meta_q, rst_sync_q;
   logic [NUM_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [NUM_BTN-1:0] sample_q, sample_d, sample_prev_q, sample_prev_d, press;
   logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
   logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
   logic [COUNT_W-1:0] count_q, count_d;
   state_e             state_q, state_d;
   logic               disp_q, disp_d, exp_q, exp_d;
   logic               deb_en, tick, dec;
   logic [EXT_W-1:0]   sum, ext;

   function automatic state_e classify(input logic [COUNT_W-1:0] c);
      if (c == '0) return ST_EXPIRED;
      else if (c < COUNT_W'(LOW_THRESH)) return ST_LOW;
      else return ST_OK;
   endfunction

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   always_comb begin
      sync1_d       = btn;
      sync2_d       = sync1_q;
      deb_en        = (deb_cnt_q == DEB_W'(DEB_CYCLES - 1));
      deb_cnt_d     = deb_en ? '0 : deb_cnt_q + DEB_W'(1);
      sample_d      = deb_en ? sync2_q : sample_q;
      sample_prev_d = sample_q;
      press         = sample_q & ~sample_prev_q;

      tick       = (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));
      tick_cnt_d = (tick || preset != 2'b00) ? '0 : tick_cnt_q + TICK_W'(1);

      sum = '0;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
         if (press[i]) sum = sum + EXT_W'(INC_LIST[i*COUNT_W +: COUNT_W]);
      end
      dec = tick && (count_q != '0);
      ext = EXT_W'(count_q) - EXT_W'(dec) + sum;

      if (preset[0]) count_d = COUNT_W'(PRESET_A);
      else if (preset[1]) count_d = COUNT_W'(PRESET_B);
      else if (ext > EXT_W'(MAX_COUNT)) count_d = COUNT_W'(MAX_COUNT);
      else count_d = ext[COUNT_W-1:0];

      state_d = classify(count_d);
      exp_d   = (count_q != '0) && (count_d == '0);

      // Any state change restarts the blink phase with the display lit.
      flash_cnt_d = '0;
      disp_d      = 1'b1;
      if (state_d == state_q && state_d != ST_OK) begin
         if (flash_cnt_q == FLASH_W'(FLASH_CYCLES - 1)) begin
            disp_d = ~disp_q;
         end else begin
            flash_cnt_d = flash_cnt_q + FLASH_W'(1);
            disp_d      = disp_q;
         end
      end
   end

`ifdef METER_BCD_OUT_EN
   logic [15:0] bcd_q, bcd_d;

   function automatic logic [15:0] to_bcd(input logic [COUNT_W-1:0] bin);
      logic [15:0] b;
      b = '0;
      for (int i = int'(COUNT_W) - 1; i >= 0; i--) begin
         for (int d = 0; d < 4; d++) begin
            if (b[d*4 +: 4] >= 4'd5) b[d*4 +: 4] = b[d*4 +: 4] + 4'd3;
         end
         b = {b[14:0], bin[i]};
      end
      return b;
   endfunction

   always_comb bcd_d = to_bcd(count_q);
   assign bcd = bcd_q;
`endif

   always_ff @(posedge clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         sample_q      <= '0;
         sample_prev_q <= '0;
         deb_cnt_q     <= '0;
         tick_cnt_q    <= '0;
         flash_cnt_q   <= '0;
         count_q       <= '0;
         state_q       <= ST_EXPIRED;
         disp_q        <= 1'b1;
         exp_q         <= 1'b0;
`ifdef METER_BCD_OUT_EN
         bcd_q         <= '0;
`endif
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         sample_q      <= sample_d;
         sample_prev_q <= sample_prev_d;
         deb_cnt_q     <= deb_cnt_d;
         tick_cnt_q    <= tick_cnt_d;
         flash_cnt_q   <= flash_cnt_d;
         count_q       <= count_d;
         state_q       <= state_d;
         disp_q        <= disp_d;
         exp_q         <= exp_d;
`ifdef METER_BCD_OUT_EN
         bcd_q         <= bcd_d;
`endif
      end
   end

   assign count         = count_q;
   assign state         = state_q;
   assign display_en    = disp_q;
   assign expired_pulse = exp_q;
endmodule

// File: tb/tb_meter_core.sv
// Self-checking bench for meter_core: vector table, hand sequences for timing corners, random run against a reference model.
module tb_meter_core;
   localparam int TICK = 20, DEB = 4, FLASH = 5, MAXC = 9999, PA = 10, PB = 205, LOWT = 200;
   localparam logic [63:0] INCS = {16'd550, 16'd200, 16'd180, 16'd10};

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  btn;
   logic [1:0]  preset;
   logic [15:0] count;
   logic [1:0]  state;
   logic        display_en, expired_pulse;
`ifdef METER_BCD_OUT_EN
   logic [15:0] bcd;
`endif

   int tests = 0, fails = 0;

   meter_core #(
      .TICK_CYCLES(TICK), .DEB_CYCLES(DEB), .NUM_BTN(4), .COUNT_W(16), .MAX_COUNT(MAXC),
      .INC_LIST(INCS), .PRESET_A(PA), .PRESET_B(PB), .LOW_THRESH(LOWT), .FLASH_CYCLES(FLASH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .btn(btn), .preset(preset),
      .count(count), .state(state), .display_en(display_en), .expired_pulse(expired_pulse)
`ifdef METER_BCD_OUT_EN
      , .bcd(bcd)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: absolute edge index since reset drives the debounce/tick schedule.
   int   inc_val[4] = '{10, 180, 200, 550};
   int   m_k, m_last_zero, m_count, m_state, m_disp, m_pulse, m_s, m_hold, m_bcd;
   logic [3:0] m_samp, m_samp_prev;
   logic [3:0] bq[$];

   function automatic int classify(input int c);
      if (c == 0) return 0;
      else if (c < LOWT) return 1;
      else return 2;
   endfunction

   function automatic int bcd_of(input int c);
      return (((c / 1000) % 10) << 12) | (((c / 100) % 10) << 8) | (((c / 10) % 10) << 4) | (c % 10);
   endfunction

   task automatic model_reset();
      m_k = 0; m_last_zero = 0; m_count = 0; m_state = 0; m_disp = 1; m_pulse = 0;
      m_s = 0; m_samp = 0; m_samp_prev = 0; m_hold = 2; m_bcd = 0;
      bq.delete();
   endtask

   task automatic model_step(input logic [3:0] b, input logic [1:0] p);
      int sum, old, ns;
      logic [3:0] pr;
      logic tk;
      if (m_hold > 0) begin
         m_hold--;
         return;
      end
      m_k++;
      bq.push_back(b);
      if (bq.size() > 3) void'(bq.pop_front());
      pr = m_samp & ~m_samp_prev;
      tk = ((m_k - m_last_zero) % TICK) == 0;
      old = m_count;
      m_bcd = bcd_of(old);
      if (p[0]) begin
         m_count = PA; m_last_zero = m_k;
      end else if (p[1]) begin
         m_count = PB; m_last_zero = m_k;
      end else begin
         sum = 0;
         for (int i = 0; i < 4; i++) if (pr[i]) sum += inc_val[i];
         m_count = m_count - ((tk && m_count != 0) ? 1 : 0) + sum;
         if (m_count > MAXC) m_count = MAXC;
      end
      m_pulse = (old != 0 && m_count == 0) ? 1 : 0;
      ns = classify(m_count);
      if (ns != m_state) m_s = 0;
      else m_s++;
      m_state = ns;
      m_disp = (ns == 2) ? 1 : (((m_s / FLASH) % 2 == 0) ? 1 : 0);
      m_samp_prev = m_samp;
      if (m_k % DEB == 0) m_samp = (bq.size() == 3) ? bq[0] : 4'b0000;
   endtask

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge: compare, drive inputs for the coming edge, advance the model.
   task automatic cyc(input logic [3:0] b, input logic [1:0] p);
      check("count", int'(count), m_count);
      check("state", int'(state), m_state);
      check("display_en", int'(display_en), m_disp);
      check("expired_pulse", int'(expired_pulse), m_pulse);
`ifdef METER_BCD_OUT_EN
      check("bcd", int'(bcd), m_bcd);
`endif
      btn = b;
      preset = p;
      model_step(b, p);
      @(negedge clk);
   endtask

   typedef struct {
      logic [1:0] p;
      logic [3:0] b;
      int         exp_count;
      int         exp_state;
   } vec_t;

   initial begin
      vec_t vecs[8];
      int pulses, toggles, last;
      logic prev;
      logic [3:0] rb;
      logic [1:0] rp;

      vecs[0] = '{2'b01, 4'b0001, 20, 1};
      vecs[1] = '{2'b10, 4'b1100, 955, 2};
      vecs[2] = '{2'b01, 4'b0010, 190, 1};
      vecs[3] = '{2'b01, 4'b1111, 950, 2};
      vecs[4] = '{2'b10, 4'b0000, 205, 2};
      vecs[5] = '{2'b10, 4'b0100, 405, 2};
      vecs[6] = '{2'b01, 4'b1000, 560, 2};
      vecs[7] = '{2'b11, 4'b0001, 20, 1};

      reset_n = 1'b0; btn = '0; preset = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_count", int'(count), 0);
      check("rst_state", int'(state), 0);
      check("rst_display_en", int'(display_en), 1);
      check("rst_expired_pulse", int'(expired_pulse), 0);
      reset_n = 1'b1;

      // Held button yields one press; ticks keep decrementing while it stays held.
      repeat (15) cyc(4'b0001, 2'b00);
      check("hold_count", int'(count), 10);
      check("hold_state", int'(state), 1);
      repeat (10) cyc(4'b0001, 2'b00);
      check("hold_tick1", int'(count), 9);
      repeat (19) cyc(4'b0001, 2'b00);
      check("hold_tick2", int'(count), 8);
      repeat (10) cyc(4'b0000, 2'b00);

      foreach (vecs[i]) begin
         repeat (2) cyc(4'b0000, vecs[i].p);
         repeat (8) cyc(vecs[i].b, 2'b00);
         repeat (6) cyc(4'b0000, 2'b00);
         check($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
         check($sformatf("vec%0d_state", i), int'(state), vecs[i].exp_state);
      end

      // Saturation at MAX_COUNT.
      repeat (2) cyc(4'b0000, 2'b10);
      for (int n = 0; n < 21; n++) begin
         repeat (8) cyc(4'b1000, 2'b00);
         repeat (6) cyc(4'b0000, 2'b00);
      end
      check("sat_range", (count >= 16'd9998 && count <= 16'd9999) ? 1 : 0, 1);
      check("sat_state", int'(state), 2);

      // Countdown to zero: one expiry strobe, then blinking every FLASH cycles.
      cyc(4'b0000, 2'b01);
      pulses = 0;
      for (int c = 0; c < 210; c++) begin
         cyc(4'b0000, 2'b00);
         if (expired_pulse) pulses++;
      end
      check("expire_pulses", pulses, 1);
      check("expire_count", int'(count), 0);
      check("expire_state", int'(state), 0);
      prev = display_en; toggles = 0; last = -1;
      for (int c = 0; c < 30; c++) begin
         cyc(4'b0000, 2'b00);
         if (display_en != prev) begin
            toggles++;
            if (last >= 0) check("flash_period", c - last, FLASH);
            last = c;
            prev = display_en;
         end
      end
      check("flash_toggles", toggles, 6);

      // Press landing exactly on a tick at count=5.
      while (((m_k + 1) % DEB) != 1) cyc(4'b0000, 2'b00);
      cyc(4'b0000, 2'b01);
      repeat (113) cyc(4'b0000, 2'b00);
      repeat (7) cyc(4'b0001, 2'b00);
      check("tick_press_count", int'(count), 14);
      cyc(4'b0001, 2'b00);
      repeat (8) cyc(4'b0000, 2'b00);

      // Asynchronous reset mid-countdown.
      cyc(4'b0000, 2'b10);
      cyc(4'b0000, 2'b00);
`ifdef METER_BCD_OUT_EN
      check("bcd_205", int'(bcd), 16'h0205);
`endif
      repeat (30) cyc(4'b0000, 2'b00);
      #7;
      reset_n = 1'b0;
      #1;
      check("async_rst_count", int'(count), 0);
      check("async_rst_state", int'(state), 0);
      check("async_rst_display_en", int'(display_en), 1);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) cyc(4'b0000, 2'b00);

      // Random traffic against the model.
      for (int seg = 0; seg < 300; seg++) begin
         rb = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         rp = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         repeat ($urandom_range(1, 12)) cyc(rb, rp);
         if ($urandom_range(0, 9) == 0) repeat (150) cyc(4'b0000, 2'b00);
      end
      cyc(4'b0000, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
